// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
// The loader connects through the slave modport.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a byte stream MSB-first into instruction words and writes them
// to consecutive instruction-memory addresses, holding the core meanwhile.
module instr_mem_loader #(
  parameter int ADDR_W    = 3,
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic [WORD_W-1:0]   checksum,
  output logic [ADDR_W:0]     word_count
);

  localparam int BYTES = WORD_W / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0]   LAST = IW'(BYTES - 1);
  localparam logic [ADDR_W:0] NW   = (ADDR_W + 1)'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] pack;
  logic [ADDR_W-1:0] addr;
  logic              ready_q;
  logic              we_q;

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = pack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pack       <= '0;
      addr       <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
      word_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            idx        <= '0;
            pack       <= '0;
            addr       <= '0;
            ready_q    <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            checksum   <= '0;
            word_count <= '0;
          end
        end
        COLLECT: begin
          if (bus.byte_valid && ready_q) begin
            pack <= (pack << 8) | WORD_W'(bus.byte_data);
            if (idx == LAST) begin
              state   <= WRITE;
              idx     <= '0;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        WRITE: begin
          we_q       <= 1'b0;
          checksum   <= checksum ^ pack;
          word_count <= word_count + 1'b1;
          // Address stays on the last word once the load completes.
          if (word_count + 1'b1 < NW) begin
            state   <= COLLECT;
            ready_q <= 1'b1;
            addr    <= addr + 1'b1;
          end else begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: cycle table, then
// randomized loads checked against a byte-to-word reference model.
module tb_instr_mem_loader;

  localparam int NW  = 8;
  localparam int LIM = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic [31:0] checksum;
  logic [3:0]  word_count;

  instr_mem_loader_if #(.ADDR_W(3), .WORD_W(32)) bus();

  instr_mem_loader #(
    .ADDR_W(3), .NUM_WORDS(NW), .WORD_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .checksum   (checksum),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  acc_total = 0;
  bit  mon_chk = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      check("we_ready_low", {63'd0, bus.byte_ready}, 64'd0);
      check("we_hold_high", {63'd0, cpu_hold}, 64'd1);
      if (mon_chk)
        check("we_after_4th", acc_total, 4 * (wr_q.size() + 1));
      wr_q.push_back('{bus.mem_addr, bus.mem_wdata});
    end
  end

  typedef struct {
    bit          r, s, v;
    logic [7:0]  d;
    bit          br, we, hold, dn;
    logic [3:0]  cnt;
    logic [2:0]  addr;
    bit          cw;
    logic [31:0] wd;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit r, s, v, input logic [7:0] d,
                     input bit br, we, hold, dn, input int cnt,
                     input int addr, input bit cw, input logic [31:0] wd);
    tv.push_back('{r, s, v, d, br, we, hold, dn, 4'(cnt), 3'(addr), cw, wd});
  endtask

  task automatic run_load(input logic [7:0] bq[$], input int pct,
                          input int exp_lat, input int start_word);
    logic [31:0] exp_w[$];
    logic [31:0] w, cs;
    int n, bi;
    bit pulsed, acc;
    exp_w.delete();
    cs = 0;
    for (int i = 0; i < NW; i++) begin
      w = 0;
      for (int k = 0; k < 4; k++) w = (w << 8) | 32'(bq[4*i+k]);
      exp_w.push_back(w);
      cs ^= w;
    end
    wr_q.delete();
    acc_total = 0;
    mon_chk = 1;
    bus.byte_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("entry_count_clr", word_count, 0);
    check("entry_csum_clr", checksum, 0);
    check("entry_ready", bus.byte_ready, 1);
    check("entry_hold", cpu_hold, 1);
    n = 1;
    bi = 0;
    pulsed = 0;
    while (done !== 1'b1 && n < LIM) begin
      bus.byte_valid = (bi < bq.size()) && ($urandom_range(99) < pct);
      bus.byte_data  = (bi < bq.size()) ? bq[bi] : 8'h00;
      start = 1'b0;
      if (start_word >= 0 && !pulsed && word_count == 4'(start_word)
          && bus.byte_ready) begin
        start = 1'b1;
        pulsed = 1;
      end
      acc = bus.byte_valid && bus.byte_ready;
      step();
      n++;
      if (acc) begin
        bi++;
        acc_total++;
      end
    end
    bus.byte_valid = 1'b0;
    start = 1'b0;
    mon_chk = 0;
    check("load_timeout", {63'd0, n < LIM}, 64'd1);
    if (exp_lat > 0) check("latency", n, exp_lat);
    check("bytes_used", bi, 4 * NW);
    check("num_writes", wr_q.size(), NW);
    for (int i = 0; i < NW && i < wr_q.size(); i++) begin
      check("wr_addr", wr_q[i].addr, i);
      check("wr_data", wr_q[i].data, exp_w[i]);
    end
    check("checksum", checksum, cs);
    check("word_count", word_count, NW);
    check("done_hold", {62'd0, done, cpu_hold}, 64'b10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("done_stable", {31'd0, done, checksum}, {31'd0, 1'b1, cs});
      check("count_stable", word_count, NW);
    end
  endtask

  logic [7:0] bq[$];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;

    // r s v data  br we hold dn cnt addr cw wdata
    add(1,0,0,8'h00, 0,0,0,0, 0,0, 1,32'h0);
    add(1,0,0,8'h00, 0,0,0,0, 0,0, 0,32'h0);
    add(0,0,1,8'hAA, 0,0,0,0, 0,0, 0,32'h0);
    add(0,0,1,8'hBB, 0,0,0,0, 0,0, 0,32'h0);
    add(0,1,0,8'h00, 1,0,1,0, 0,0, 0,32'h0);
    add(0,0,1,8'h11, 1,0,1,0, 0,0, 0,32'h0);
    add(0,0,1,8'h22, 1,0,1,0, 0,0, 0,32'h0);
    add(1,0,0,8'h00, 0,0,0,0, 0,0, 1,32'h0);
    add(0,0,1,8'h33, 0,0,0,0, 0,0, 0,32'h0);
    add(0,1,0,8'h00, 1,0,1,0, 0,0, 0,32'h0);
    add(0,0,1,8'hDE, 1,0,1,0, 0,0, 0,32'h0);
    add(0,0,1,8'hAD, 1,0,1,0, 0,0, 0,32'h0);
    add(0,0,1,8'hBE, 1,0,1,0, 0,0, 0,32'h0);
    add(0,0,1,8'hEF, 0,1,1,0, 0,0, 1,32'hDEADBEEF);
    add(0,0,0,8'h00, 1,0,1,0, 1,1, 0,32'h0);
    add(0,0,1,8'h01, 1,0,1,0, 1,1, 0,32'h0);
    add(0,0,1,8'h02, 1,0,1,0, 1,1, 0,32'h0);
    add(0,0,1,8'h03, 1,0,1,0, 1,1, 0,32'h0);
    add(0,0,1,8'h04, 0,1,1,0, 1,1, 1,32'h01020304);
    add(1,0,0,8'h00, 0,0,0,0, 0,0, 1,32'h0);

    foreach (tv[i]) begin
      rst = tv[i].r;
      start = tv[i].s;
      bus.byte_valid = tv[i].v;
      bus.byte_data = tv[i].d;
      step();
      check($sformatf("tv%0d_ctl", i),
            {bus.byte_ready, bus.mem_we, cpu_hold, done, word_count},
            {tv[i].br, tv[i].we, tv[i].hold, tv[i].dn, tv[i].cnt});
      check($sformatf("tv%0d_addr", i), bus.mem_addr, tv[i].addr);
      if (tv[i].cw)
        check($sformatf("tv%0d_wdata", i), bus.mem_wdata, tv[i].wd);
    end
    check("tv_csum_reset", checksum, 0);

    // Idle after reset: random valid pulses must not move anything.
    rst = 1'b1;
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.byte_valid = 1'($urandom_range(1));
      bus.byte_data = 8'($urandom);
      step();
      check("idle_outs",
            {bus.byte_ready, bus.mem_we, cpu_hold, done, word_count,
             bus.mem_addr, checksum},
            '0);
    end
    bus.byte_valid = 1'b0;

    bq.delete();
    for (int i = 0; i < 4 * NW; i++) bq.push_back(8'(i));
    run_load(bq, 100, 1 + 5 * NW, -1);
    if (wr_q.size() == NW) begin
      check("word0_lit", wr_q[0].data, 32'h00010203);
      check("word7_lit", wr_q[7].data, 32'h1C1D1E1F);
    end
    check("csum_lit", checksum, 32'h0);

    run_load(bq, 30, 0, -1);

    bq.delete();
    for (int i = 0; i < 4 * NW; i++) bq.push_back(8'hFF);
    run_load(bq, 100, 1 + 5 * NW, -1);
    check("ff_csum_lit", checksum, 32'h0);

    bq.delete();
    for (int i = 0; i < 4 * NW; i++) bq.push_back(8'($urandom));
    run_load(bq, 100, 1 + 5 * NW, 3);

    for (int r = 0; r < 4; r++) begin
      bq.delete();
      for (int i = 0; i < 4 * NW; i++) bq.push_back(8'($urandom));
      run_load(bq, int'($urandom_range(100, 20)), 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
